// File: rtl/sipo_in.sv
// Serial-in, parallel-out collector: shifts WIDTH-bit elements into a tap
// chain and presents NUM_TAPS of them as one word under a valid/ack handshake.
module sipo_in #(
  parameter int WIDTH    = 8,
  parameter int NUM_TAPS = 4,
  parameter int CNT_W    = $clog2(NUM_TAPS + 1)
) (
  input  logic                      CLKEXT,
  input  logic                      CLR_PISO_OUT,
  input  logic                      SHIFT_IN,
  input  logic [WIDTH-1:0]          DATA_IN,
  input  logic                      LOAD_ACK,
  output logic [WIDTH*NUM_TAPS-1:0] DATA_OUT,
  output logic                      FULL,
  output logic [CNT_W-1:0]          COUNT,
  output logic                      OVERRUN
);

  logic [WIDTH-1:0] tap_q [NUM_TAPS];
  logic [WIDTH-1:0] tap_d [NUM_TAPS];
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             full;
  logic             accept;
  logic             drain;

  assign full   = (count_q == CNT_W'(NUM_TAPS));
  assign accept = SHIFT_IN & (~full | LOAD_ACK);
  assign drain  = full & LOAD_ACK;

  always_comb begin
    tap_d     = tap_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (accept) begin
      tap_d[0] = DATA_IN;
      for (int i = 1; i < NUM_TAPS; i++) begin
        tap_d[i] = tap_q[i-1];
      end
    end
    // A drain that coincides with an accept makes the new element the
    // first of the next word.
    if (drain && accept) begin
      count_d = CNT_W'(1);
    end else if (drain) begin
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + CNT_W'(1);
    end
    if (SHIFT_IN && full && !LOAD_ACK) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLKEXT or posedge CLR_PISO_OUT) begin
    if (CLR_PISO_OUT) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        tap_q[i] <= '0;
      end
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      tap_q     <= tap_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_lane
    assign DATA_OUT[WIDTH*gi +: WIDTH] = tap_q[gi];
  end

  assign FULL    = full;
  assign COUNT   = count_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_sipo_in.sv
// Directed bench for sipo_in: completed words go through a scoreboard queue
// checked by a monitor on FULL rising; counters and flags are checked inline.
module tb_sipo_in;

  localparam int WIDTH    = 8;
  localparam int NUM_TAPS = 4;
  localparam int CNT_W    = $clog2(NUM_TAPS + 1);
  localparam int DW       = WIDTH * NUM_TAPS;

  logic              CLKEXT;
  logic              CLR_PISO_OUT;
  logic              SHIFT_IN;
  logic [WIDTH-1:0]  DATA_IN;
  logic              LOAD_ACK;
  logic [DW-1:0]     DATA_OUT;
  logic              FULL;
  logic [CNT_W-1:0]  COUNT;
  logic              OVERRUN;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_q [$];
  logic          full_seen = 1'b0;

  sipo_in #(.WIDTH(WIDTH), .NUM_TAPS(NUM_TAPS)) dut (
    .CLKEXT      (CLKEXT),
    .CLR_PISO_OUT(CLR_PISO_OUT),
    .SHIFT_IN    (SHIFT_IN),
    .DATA_IN     (DATA_IN),
    .LOAD_ACK    (LOAD_ACK),
    .DATA_OUT    (DATA_OUT),
    .FULL        (FULL),
    .COUNT       (COUNT),
    .OVERRUN     (OVERRUN)
  );

  initial begin
    CLKEXT = 1'b0;
    forever #5 CLKEXT = ~CLKEXT;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %s: got 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic [WIDTH-1:0] d, input logic a);
    SHIFT_IN = s;
    DATA_IN  = d;
    LOAD_ACK = a;
    @(posedge CLKEXT);
    #1;
    SHIFT_IN = 1'b0;
    LOAD_ACK = 1'b0;
  endtask

  // Reset pulse placed between edges; state must clear before any edge.
  task automatic pulse_reset(input string name);
    #1 CLR_PISO_OUT = 1'b1;
    #1;
    chk({name, "_data"},    64'(DATA_OUT), 64'h0);
    chk({name, "_count"},   64'(COUNT),    64'h0);
    chk({name, "_full"},    64'(FULL),     64'h0);
    chk({name, "_overrun"}, 64'(OVERRUN),  64'h0);
    #1 CLR_PISO_OUT = 1'b0;
  endtask

  // Monitor: each rising FULL presents one word to compare.
  always @(negedge CLKEXT) begin
    if (FULL && !full_seen) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL word_unexpected: got 0x%0h expected no word", DATA_OUT);
      end else begin
        chk("word", 64'(DATA_OUT), 64'(exp_q.pop_front()));
      end
    end
    full_seen = FULL;
  end

  initial begin
    logic [DW-1:0] piso_word;
    CLR_PISO_OUT = 1'b1;
    SHIFT_IN     = 1'b0;
    DATA_IN      = '0;
    LOAD_ACK     = 1'b0;
    #12;
    chk("por_count", 64'(COUNT), 64'h0);
    chk("por_data",  64'(DATA_OUT), 64'h0);
    CLR_PISO_OUT = 1'b0;

    // Reset check
    cyc(1'b1, 8'h11, 1'b0);
    pulse_reset("rst1");
    cyc(1'b1, 8'hAB, 1'b0);
    chk("rst_ab_data",  64'(DATA_OUT), 64'h0000_00AB);
    chk("rst_ab_count", 64'(COUNT),    64'h1);
    pulse_reset("rst2");

    // Basic fill
    cyc(1'b1, 8'h11, 1'b0); chk("fill_c1", 64'(COUNT), 64'h1);
    cyc(1'b1, 8'h22, 1'b0); chk("fill_c2", 64'(COUNT), 64'h2);
    cyc(1'b1, 8'h33, 1'b0); chk("fill_c3", 64'(COUNT), 64'h3);
    chk("fill_notfull", 64'(FULL), 64'h0);
    exp_q.push_back(32'h1122_3344);
    cyc(1'b1, 8'h44, 1'b0); chk("fill_c4", 64'(COUNT), 64'h4);
    chk("fill_full", 64'(FULL), 64'h1);
    chk("fill_data", 64'(DATA_OUT), 64'h1122_3344);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drain_count", 64'(COUNT), 64'h0);
    chk("drain_full",  64'(FULL),  64'h0);

    // Seamless stream
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    exp_q.push_back(32'h1122_3344);
    cyc(1'b1, 8'h44, 1'b0);
    cyc(1'b1, 8'h55, 1'b1);
    chk("seam_count", 64'(COUNT), 64'h1);
    chk("seam_full",  64'(FULL),  64'h0);
    chk("seam_tap0",  64'(DATA_OUT[7:0]), 64'h55);
    cyc(1'b1, 8'h66, 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    exp_q.push_back(32'h5566_7788);
    cyc(1'b1, 8'h88, 1'b0);
    chk("seam_full2",   64'(FULL),     64'h1);
    chk("seam_data",    64'(DATA_OUT), 64'h5566_7788);
    chk("seam_overrun", 64'(OVERRUN),  64'h0);
    cyc(1'b0, 8'h00, 1'b1);

    // Overrun
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    exp_q.push_back(32'h1122_3344);
    cyc(1'b1, 8'h44, 1'b0);
    chk("ovr_pre", 64'(OVERRUN), 64'h0);
    cyc(1'b1, 8'h99, 1'b0);
    chk("ovr_data",  64'(DATA_OUT), 64'h1122_3344);
    chk("ovr_count", 64'(COUNT),    64'h4);
    chk("ovr_flag",  64'(OVERRUN),  64'h1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("ovr_sticky",      64'(OVERRUN), 64'h1);
    chk("ovr_drain_count", 64'(COUNT),   64'h0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovr_sticky2", 64'(OVERRUN), 64'h1);
    pulse_reset("rst3");

    // Spurious ack and gaps
    cyc(1'b1, 8'h01, 1'b0);
    repeat (3) cyc(1'b0, 8'hFF, 1'b0);
    chk("gap_count", 64'(COUNT), 64'h1);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("spur_count", 64'(COUNT), 64'h2);
    chk("spur_full",  64'(FULL),  64'h0);
    chk("spur_data",  64'(DATA_OUT), 64'h0000_0102);
    cyc(1'b1, 8'h03, 1'b0);
    exp_q.push_back(32'h0102_0304);
    cyc(1'b1, 8'h04, 1'b0);
    chk("gap_data", 64'(DATA_OUT), 64'h0102_0304);
    cyc(1'b0, 8'h00, 1'b1);

    // Mid-word reset and loopback from a PISO (highest lane first)
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    cyc(1'b1, 8'hCC, 1'b0);
    chk("mid_count", 64'(COUNT), 64'h3);
    pulse_reset("rst_mid");
    piso_word = 32'hDEAD_BEEF;
    exp_q.push_back(piso_word);
    for (int i = NUM_TAPS - 1; i >= 0; i--) begin
      cyc(1'b1, piso_word[WIDTH*i +: WIDTH], 1'b0);
    end
    chk("loop_full", 64'(FULL),     64'h1);
    chk("loop_data", 64'(DATA_OUT), 64'hDEAD_BEEF);
    cyc(1'b0, 8'h00, 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sipo_in.md
# sipo_in

Serial-in, parallel-out collector on the NPU input path. It accepts one WIDTH-bit element per strobed CLKEXT edge and assembles NUM_TAPS elements into one parallel word for the datapath, using a valid/acknowledge handshake. Lane order matches the output-side PISO, so a word serialized by the PISO and received by this block is rebuilt bit-exact.

## Interface
- WIDTH, 8, bits per serial element.
- NUM_TAPS, 4, elements per parallel word; must be ≥ 2.
- CNT_W, $clog2(NUM_TAPS+1), derived width of COUNT.

- CLKEXT  input  1  clock; all state updates on the rising edge.
- CLR_PISO_OUT  input  1  reset, asynchronous, active-high.
- SHIFT_IN  input  1  strobe: DATA_IN holds a valid element this cycle.
- DATA_IN  input  WIDTH  serial element.
- LOAD_ACK  input  1  consumer takes DATA_OUT this cycle; meaningful only while FULL=1.
- DATA_OUT  output  WIDTH*NUM_TAPS  assembled word; lane i = DATA_OUT[WIDTH*i +: WIDTH].
- FULL  output  1  word complete and valid (COUNT == NUM_TAPS).
- COUNT  output  CNT_W  elements held, 0..NUM_TAPS.
- OVERRUN  output  1  sticky error flag: an element was dropped.

## Operation
- Storage is a NUM_TAPS × WIDTH register array, tap[0..NUM_TAPS-1]. DATA_OUT is the direct concatenation of the taps, with tap i in lane i. There is no output register stage.
- An element is accepted when SHIFT_IN=1 and (FULL=0 or LOAD_ACK=1). On acceptance:
  - tap[0] ← DATA_IN;
  - tap[i] ← tap[i-1] for i = 1..NUM_TAPS-1.
- The first element of a word ends in lane NUM_TAPS-1 and the last in lane 0.
- COUNT update per edge, with acc = accepted and drain = FULL & LOAD_ACK:
  - drain=0, acc=1: COUNT+1.
  - drain=1, acc=0: 0.
  - drain=1, acc=1: 1. The new element starts the next word.
  - otherwise: hold.
- LOAD_ACK while FULL=0 is ignored. It does not change COUNT, taps, or flags.
- Overrun: if SHIFT_IN=1, FULL=1 and LOAD_ACK=0, the element is dropped. Taps and COUNT hold, and OVERRUN sets to 1. OVERRUN stays set until reset.
- After a drain, the taps keep their old contents until they are overwritten. Consumers must qualify DATA_OUT with FULL.
- States are implicit in COUNT:
  - EMPTY: COUNT = 0.
  - FILLING: 0 < COUNT < NUM_TAPS.
  - FULL: COUNT = NUM_TAPS.
  - FULL → EMPTY on a drain with no accept; FULL → FILLING (COUNT = 1) on a drain with an accept.
- Reset: all taps 0, COUNT 0, FULL 0, OVERRUN 0, so DATA_OUT = 0. Reset takes effect immediately, including mid-word; a partial word is discarded.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from any input to any output.
- Element accepted at edge k: visible in tap[0] and COUNT after edge k.
- FULL rises after the edge that accepts element NUM_TAPS, so latency from the last element to word valid is 1 cycle. Back-to-back SHIFT_IN gives a word every NUM_TAPS cycles.
- Full throughput with no bubbles: assert LOAD_ACK in the same cycle as the next SHIFT_IN while FULL=1.
- Any deassertion of CLR_PISO_OUT releases all state together; the first edge after release may accept an element.
- SHIFT_IN low holds all state indefinitely, so gaps between elements are allowed.

## Test plan
All scenarios use WIDTH=8, NUM_TAPS=4.
- Reset check: assert CLR_PISO_OUT between clock edges -> DATA_OUT=0, COUNT=0, FULL=0, OVERRUN=0 immediately. After release, SHIFT_IN with 0xAB -> DATA_OUT=0x000000AB, COUNT=1.
- Basic fill: SHIFT_IN on 4 consecutive edges with 0x11, 0x22, 0x33, 0x44 -> COUNT steps 1, 2, 3, 4; FULL=1 after the 4th edge; DATA_OUT=0x11223344. Pulse LOAD_ACK -> COUNT=0, FULL=0.
- Seamless stream: 0x11..0x44, then SHIFT_IN 0x55 with LOAD_ACK=1 in the same cycle -> COUNT=1, FULL=0, tap[0]=0x55. Continue 0x66, 0x77, 0x88 -> DATA_OUT=0x55667788, FULL=1, OVERRUN=0.
- Overrun: fill 0x11..0x44, then SHIFT_IN 0x99 with LOAD_ACK=0 -> DATA_OUT stays 0x11223344, COUNT=4, OVERRUN=1. OVERRUN stays 1 after a later LOAD_ACK and clears only on reset.
- Spurious ack and gaps: LOAD_ACK at COUNT=2 -> no change. Then send 0x01, idle 3 cycles, 0x02, 0x03, 0x04 -> DATA_OUT=0x01020304 (with the first 2 elements in lanes 3 and 2).
- Mid-word reset and loopback: assert reset at COUNT=3 -> all state 0 immediately. Then drive from the PISO loaded with 0xDEADBEEF -> FULL with DATA_OUT=0xDEADBEEF.
